// File: rtl/mem_ctrl.sv
// Byte-serialising memory controller: arbitrates IF fetches and MEM loads/stores
// onto one synchronous byte-wide RAM port and raises per-stage stall requests.
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_inst,
    output logic              if_stall,
    input  logic              mem_req,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [2:0]        mem_len,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic              mem_stall,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic        own_mem;
    logic        wr;
    logic [2:0]  n;
    logic [2:0]  cnt;
    logic [31:0] data;
    logic [2:0]  req_len;
    logic [1:0]  rd_idx;
    logic [31:0] rd_data;

    assign if_stall  = ~rst & if_req & ~if_done;
    assign mem_stall = ~rst & mem_req & ~mem_done;

    always_comb begin
        req_len = 3'd4;
        if (mem_len == 3'd1)
            req_len = 3'd1;
        else if (mem_len == 3'd2)
            req_len = 3'd2;
    end

    // cnt counts edges since accept; the byte arriving on ram_din at edge Ek is byte k-2
    always_comb begin
        rd_idx  = 2'(cnt - 3'd2);
        rd_data = data;
        if (cnt >= 3'd2)
            rd_data[{rd_idx, 3'b000} +: 8] = ram_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            own_mem   <= 1'b0;
            wr        <= 1'b0;
            n         <= 3'd0;
            cnt       <= 3'd0;
            data      <= '0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_inst   <= '0;
            mem_rdata <= '0;
            ram_a     <= '0;
            ram_wr    <= 1'b0;
            ram_dout  <= '0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem_req) begin
                        own_mem <= 1'b1;
                        wr      <= mem_wr;
                        n       <= req_len;
                        cnt     <= 3'd1;
                        ram_a   <= mem_addr;
                        state   <= S_BUSY;
                        if (mem_wr) begin
                            data     <= mem_wdata;
                            ram_dout <= mem_wdata[7:0];
                            ram_wr   <= 1'b1;
                        end else begin
                            data <= '0;
                        end
                    end else if (if_req && !clear) begin
                        own_mem <= 1'b0;
                        wr      <= 1'b0;
                        n       <= 3'd4;
                        cnt     <= 3'd1;
                        ram_a   <= if_addr;
                        data    <= '0;
                        state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!own_mem && clear) begin
                        state <= S_IDLE;
                    end else if (wr) begin
                        if (cnt == n) begin
                            ram_wr   <= 1'b0;
                            mem_done <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            ram_a    <= ram_a + ADDR_W'(1);
                            ram_dout <= data[{cnt[1:0], 3'b000} +: 8];
                            cnt      <= cnt + 3'd1;
                        end
                    end else begin
                        if (cnt < n)
                            ram_a <= ram_a + ADDR_W'(1);
                        data <= rd_data;
                        if (cnt == 3'(n + 3'd1)) begin
                            state <= S_DONE;
                            if (own_mem) begin
                                mem_rdata <= rd_data;
                                mem_done  <= 1'b1;
                            end else begin
                                if_inst <= rd_data;
                                if_done <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
